// File: rtl/game_mode_controller_if.sv
// Bundles the game-mode controller's button/status inputs and mode outputs.
// Latency: none, this is a wiring bundle only.
// Backpressure: none, all signals are levels or single-cycle pulses.
interface game_mode_controller_if #(
    parameter int CNT_W = 4
);
    logic             btn_reset;
    logic             btn_combo;
    logic             pause_sw;
    logic             game_over;
    logic [2:0]       state;
    logic [CNT_W-1:0] countdown;
    logic             display_combo_en;
    logic             state_changed;

    // Stimulus side: drives the buttons and game status, observes the mode.
    modport master (
        output btn_reset, btn_combo, pause_sw, game_over,
        input  state, countdown, display_combo_en, state_changed
    );

    // Controller side.
    modport slave (
        input  btn_reset, btn_combo, pause_sw, game_over,
        output state, countdown, display_combo_en, state_changed
    );
endinterface

// File: rtl/game_mode_controller.sv
// Game mode FSM (RESET/COUNTDOWN/GAME/PAUSE/OVER) with synchronized, debounced buttons.
// Latency: raw button to mode change = 2 sync + DEBOUNCE_CYCLES + 1 clocks.
// Backpressure: none; all outputs are registered levels or one-cycle pulses.
module game_mode_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 8,
    parameter int COUNTDOWN_TICKS = 3,
    parameter int CNT_W           = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    game_mode_controller_if.slave ctrl
);
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COUNTDOWN_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_GAME      = 3'd2,
        S_PAUSE     = 3'd3,
        S_OVER      = 3'd4
    } state_t;

    // Bit index of each raw input inside the synchronizer/debouncer vectors.
    localparam int IDX_RESET = 0;
    localparam int IDX_COMBO = 1;
    localparam int IDX_PAUSE = 2;

    logic [1:0]      rst_sync;
    logic            run;
    logic [2:0]      raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      deb;
    logic [DB_W-1:0] db_cnt [3];
    logic            deb_reset_q;
    logic            rst_evt;

    state_t           cur_state;
    state_t           nxt_state;
    logic [CNT_W-1:0] countdown;
    logic [CNT_W-1:0] nxt_countdown;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] nxt_div;
    logic             state_changed;
    logic             display_combo_en;

    assign raw     = {ctrl.pause_sw, ctrl.btn_combo, ctrl.btn_reset};
    assign run     = rst_sync[1];
    assign rst_evt = deb[IDX_RESET] & ~deb_reset_q;

    // Reset release is retimed through two flops; everything else waits for run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    // Two-flop synchronizers followed by per-input consecutive-sample debouncers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            deb         <= '0;
            deb_reset_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else if (run) begin
            sync1       <= raw;
            sync2       <= sync1;
            deb_reset_q <= deb[IDX_RESET];
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        deb[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Next mode, countdown and divider; a reset-button event overrides everything.
    always_comb begin
        nxt_state     = cur_state;
        nxt_countdown = countdown;
        nxt_div       = div;
        if (rst_evt) begin
            nxt_state     = S_RESET;
            nxt_countdown = '0;
            nxt_div       = '0;
        end else begin
            case (cur_state)
                S_RESET: begin
                    if (!deb[IDX_PAUSE]) begin
                        nxt_state     = S_COUNTDOWN;
                        nxt_countdown = CNT_LOAD;
                        nxt_div       = '0;
                    end
                end
                S_COUNTDOWN: begin
                    if (deb[IDX_PAUSE]) begin
                        nxt_state     = S_PAUSE;
                        nxt_countdown = '0;
                        nxt_div       = '0;
                    end else if (div == DIV_LAST) begin
                        nxt_div = '0;
                        if (countdown == CNT_ONE) begin
                            nxt_state     = S_GAME;
                            nxt_countdown = '0;
                        end else begin
                            nxt_countdown = countdown - CNT_ONE;
                        end
                    end else begin
                        nxt_div = div + DIV_W'(1);
                    end
                end
                S_GAME: begin
                    if (ctrl.game_over) begin
                        nxt_state = S_OVER;
                    end else if (deb[IDX_PAUSE]) begin
                        nxt_state = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (!deb[IDX_PAUSE]) begin
                        nxt_state     = S_COUNTDOWN;
                        nxt_countdown = CNT_LOAD;
                        nxt_div       = '0;
                    end
                end
                S_OVER: begin
                    nxt_state = S_OVER;
                end
                default: begin
                    nxt_state     = S_RESET;
                    nxt_countdown = '0;
                    nxt_div       = '0;
                end
            endcase
        end
    end

    // Mode register plus registered change pulse and combo-display enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state        <= S_RESET;
            countdown        <= '0;
            div              <= '0;
            state_changed    <= 1'b0;
            display_combo_en <= 1'b0;
        end else if (run) begin
            cur_state        <= nxt_state;
            countdown        <= nxt_countdown;
            div              <= nxt_div;
            state_changed    <= (nxt_state != cur_state);
            display_combo_en <= ((cur_state == S_PAUSE) || (cur_state == S_OVER))
                                && deb[IDX_COMBO];
        end
    end

    assign ctrl.state            = cur_state;
    assign ctrl.countdown        = countdown;
    assign ctrl.state_changed    = state_changed;
    assign ctrl.display_combo_en = display_combo_en;

endmodule

// File: tb/tb_game_mode_controller.sv
// Directed bench for game_mode_controller with default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected values are hand-computed per step.
module tb_game_mode_controller;
    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;
    int   sc_pulses;
    int   reset_entries;

    game_mode_controller_if #(.CNT_W(4)) bus ();

    game_mode_controller #(
        .DEBOUNCE_CYCLES(4),
        .TICK_DIV(8),
        .COUNTDOWN_TICKS(3),
        .CNT_W(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ctrl (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] st, input logic [7:0] cnt,
                             input logic [7:0] sc, input logic [7:0] dce);
        check({tag, ".state"}, 8'(bus.state), st);
        check({tag, ".countdown"}, 8'(bus.countdown), cnt);
        check({tag, ".state_changed"}, 8'(bus.state_changed), sc);
        check({tag, ".combo_en"}, 8'(bus.display_combo_en), dce);
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        sc_pulses     = 0;
        reset_entries = 0;
        rst_n         = 1'b0;
        bus.btn_reset = 1'b0;
        bus.btn_combo = 1'b0;
        bus.pause_sw  = 1'b0;
        bus.game_over = 1'b0;

        // Reset values before any clock edge.
        #2;
        check_all("async_reset", 0, 0, 0, 0);
        cyc(3);
        check_all("held_reset", 0, 0, 0, 0);

        // Release: two sync flops, then RESET -> COUNTDOWN.
        rst_n = 1'b1;
        cyc(1);
        check_all("release_e1", 0, 0, 0, 0);
        cyc(1);
        check_all("release_e2", 0, 0, 0, 0);
        cyc(1);
        check_all("cd_entry", 1, 3, 1, 0);
        cyc(1);
        check_all("cd_e1", 1, 3, 0, 0);
        cyc(6);
        check("cd_e7", 8'(bus.countdown), 3);
        cyc(1);
        check("cd_e8", 8'(bus.countdown), 2);
        cyc(8);
        check("cd_e16", 8'(bus.countdown), 1);
        cyc(7);
        check_all("cd_e23", 1, 1, 0, 0);
        cyc(1);
        check_all("game_e24", 2, 0, 1, 0);
        cyc(1);
        check("game_e25.sc", 8'(bus.state_changed), 0);

        // Three-cycle pause glitch is rejected.
        bus.pause_sw = 1'b1;
        cyc(3);
        bus.pause_sw = 1'b0;
        cyc(10);
        check_all("glitch", 2, 0, 0, 0);

        // Held pause: PAUSE 7 cycles after the raw edge.
        bus.pause_sw = 1'b1;
        cyc(6);
        check("pause_e6", 8'(bus.state), 2);
        cyc(1);
        check_all("pause_e7", 3, 0, 1, 0);

        // Combo display in PAUSE.
        bus.btn_combo = 1'b1;
        cyc(6);
        check("combo_e6", 8'(bus.display_combo_en), 0);
        cyc(1);
        check("combo_e7", 8'(bus.display_combo_en), 1);

        // Unpause: reload countdown, combo enable drops a cycle later.
        bus.pause_sw = 1'b0;
        cyc(6);
        check_all("unpause_e6", 3, 0, 0, 1);
        cyc(1);
        check_all("unpause_e7", 1, 3, 1, 1);
        cyc(1);
        check_all("unpause_e8", 1, 3, 0, 0);
        bus.btn_combo = 1'b0;
        cyc(23);
        check_all("regame", 2, 0, 1, 0);

        // game_over rises in the same cycle debounced pause rises: OVER wins.
        bus.pause_sw = 1'b1;
        cyc(6);
        check("both_pre", 8'(bus.state), 2);
        bus.game_over = 1'b1;
        cyc(1);
        check_all("over_entry", 4, 0, 1, 0);
        bus.game_over = 1'b0;
        bus.pause_sw  = 1'b0;
        cyc(10);
        check_all("over_hold1", 4, 0, 0, 0);
        bus.game_over = 1'b1;
        bus.pause_sw  = 1'b1;
        cyc(10);
        check_all("over_hold2", 4, 0, 0, 0);
        bus.game_over = 1'b0;
        bus.btn_combo = 1'b1;
        cyc(7);
        check("over_combo", 8'(bus.display_combo_en), 1);

        // Reset button exits OVER; pause still high keeps RESET.
        bus.btn_reset = 1'b1;
        cyc(6);
        check("rstbtn_e6", 8'(bus.state), 4);
        cyc(1);
        check_all("rstbtn_e7", 0, 0, 1, 1);
        cyc(1);
        check_all("rstbtn_e8", 0, 0, 0, 0);
        bus.btn_reset = 1'b0;
        bus.btn_combo = 1'b0;
        cyc(10);
        check_all("reset_paused", 0, 0, 0, 0);
        bus.pause_sw = 1'b0;
        cyc(7);
        check_all("reset_to_cd", 1, 3, 1, 0);
        cyc(24);
        check_all("game3", 2, 0, 1, 0);

        // Held reset button: one event only.
        bus.btn_reset = 1'b1;
        for (int i = 0; i < 110; i++) begin
            if (i == 100) bus.btn_reset = 1'b0;
            cyc(1);
            if (bus.state_changed === 1'b1) begin
                sc_pulses++;
                if (bus.state === 3'd0) reset_entries++;
            end
        end
        check("held_reset_entries", 8'(reset_entries), 1);
        check("held_sc_pulses", 8'(sc_pulses), 3);
        check("held_final_state", 8'(bus.state), 2);

        // Async rst_n in the middle of a countdown.
        bus.btn_reset = 1'b1;
        cyc(8);
        check_all("cd2_entry", 1, 3, 1, 0);
        bus.btn_reset = 1'b0;
        cyc(8);
        check("cd2_at2", 8'(bus.countdown), 2);
        bus.pause_sw = 1'b1;
        cyc(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("midcd_async", 0, 0, 0, 0);
        bus.pause_sw = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
        check_all("rerelease_e2", 0, 0, 0, 0);
        cyc(1);
        check_all("rerelease_e3", 1, 3, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
